// File: rtl/execute_out_buffer_if.sv
// execute_out_buffer_if: execute-to-writeback result handshake bundle
interface execute_out_buffer_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_W_control;
  logic [DATA_W-1:0] in_aluout;
  logic [DATA_W-1:0] in_pcout;
  logic [REG_W-1:0]  in_dr;
  logic [REG_W-1:0]  in_sr1;
  logic [REG_W-1:0]  in_sr2;
  logic [DATA_W-1:0] in_IR;
  logic [DATA_W-1:0] in_M_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_W_control;
  logic [DATA_W-1:0] out_aluout;
  logic [DATA_W-1:0] out_pcout;
  logic [REG_W-1:0]  out_dr;
  logic [REG_W-1:0]  out_sr1;
  logic [REG_W-1:0]  out_sr2;
  logic [DATA_W-1:0] out_IR_Exec;
  logic [2:0]        out_NZP;
  logic [DATA_W-1:0] out_M_data;
  modport master (
    input  in_valid, in_W_control, in_aluout, in_pcout, in_dr, in_sr1, in_sr2, in_IR, in_M_data, out_ready,
    output in_ready, out_valid, out_W_control, out_aluout, out_pcout, out_dr, out_sr1, out_sr2,
           out_IR_Exec, out_NZP, out_M_data
  );
  modport slave (
    output in_valid, in_W_control, in_aluout, in_pcout, in_dr, in_sr1, in_sr2, in_IR, in_M_data, out_ready,
    input  in_ready, out_valid, out_W_control, out_aluout, out_pcout, out_dr, out_sr1, out_sr2,
           out_IR_Exec, out_NZP, out_M_data
  );
endinterface

// File: rtl/execute_out_buffer.sv
// execute_out_buffer: DEPTH-entry in-order result queue with NZP generated at capture
module execute_out_buffer #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  execute_out_buffer_if.master bus,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int E_W   = 2 + 4 * DATA_W + 3 * REG_W + 3;
  logic [E_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] v;
  logic [2:0]        nzp;
  logic              push, pop;
  always_comb begin
    v       = bus.in_W_control[1] ? bus.in_pcout : bus.in_aluout;
    nzp     = bus.in_W_control[0] ? 3'b000 : v[DATA_W-1] ? 3'b100 : (v == '0) ? 3'b010 : 3'b001;
    push    = bus.in_valid && bus.in_ready;
    pop     = bus.out_valid && bus.out_ready;
    wr_d    = push ? (wr_q == PTR_W'(DEPTH - 1) ? '0 : wr_q + PTR_W'(1)) : wr_q;
    rd_d    = pop ? (rd_q == PTR_W'(DEPTH - 1) ? '0 : rd_q + PTR_W'(1)) : rd_q;
    count_d = (push && !pop) ? count_q + CNT_W'(1) : (pop && !push) ? count_q - CNT_W'(1) : count_q;
  end
  // in_ready comes only from registered occupancy, so a pop never frees a slot in the same cycle
  assign bus.in_ready  = count_q < CNT_W'(DEPTH);
  assign bus.out_valid = count_q != '0;
  assign count         = count_q;
  assign {bus.out_W_control, bus.out_aluout, bus.out_pcout, bus.out_dr, bus.out_sr1, bus.out_sr2,
          bus.out_IR_Exec, bus.out_NZP, bus.out_M_data} = mem_q[rd_q];
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (push) mem_q[wr_q] <= {bus.in_W_control, bus.in_aluout, bus.in_pcout, bus.in_dr, bus.in_sr1,
                                bus.in_sr2, bus.in_IR, nzp, bus.in_M_data};
    end
  end
endmodule

// File: tb/tb_execute_out_buffer.sv
// tb_execute_out_buffer: directed checks on a DEPTH=2 and a DEPTH=3 buffer
module tb_execute_out_buffer;
  logic       clock = 0;
  logic       reset = 0;
  logic       flush2 = 0;
  logic       flush3 = 0;
  logic [1:0] count2;
  logic [1:0] count3;
  int         n_cmp = 0;
  int         n_bad = 0;
  always #5 clock = ~clock;
  execute_out_buffer_if #(.DATA_W(16), .REG_W(3)) i2 ();
  execute_out_buffer_if #(.DATA_W(16), .REG_W(3)) i3 ();
  execute_out_buffer #(.DATA_W(16), .REG_W(3), .DEPTH(2)) u2 (
    .clock(clock), .reset(reset), .flush(flush2), .bus(i2.master), .count(count2));
  execute_out_buffer #(.DATA_W(16), .REG_W(3), .DEPTH(3)) u3 (
    .clock(clock), .reset(reset), .flush(flush3), .bus(i3.master), .count(count3));
  always @(negedge clock) begin
    n_cmp += 2;
    if (count2 > 2) begin n_bad++; $display("FAIL occupancy2 count=%0d max=2", count2); end
    if (count3 > 3) begin n_bad++; $display("FAIL occupancy3 count=%0d max=3", count3); end
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic set2(input logic [1:0] wc, input logic [15:0] alu, input logic [15:0] pc, input logic [15:0] ir);
    i2.in_W_control = wc;
    i2.in_aluout    = alu;
    i2.in_pcout     = pc;
    i2.in_IR        = ir;
    i2.in_dr        = ir[2:0];
    i2.in_sr1       = ir[5:3];
    i2.in_sr2       = ir[8:6];
    i2.in_M_data    = ~ir;
  endtask
  task automatic test_reset();
    set2(2'b00, 16'h1234, 16'h5678, 16'h9abc);
    i2.in_valid = 1; i2.out_ready = 1;
    reset = 1; step(); step();
    reset = 0; i2.in_valid = 0; i2.out_ready = 0;
    step();
    n_cmp += 7;
    if (count2 !== 2'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count2); end
    if (i2.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", i2.out_valid); end
    if (i2.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", i2.in_ready); end
    if (i2.out_aluout !== 16'h0) begin n_bad++; $display("FAIL reset_aluout got=%h exp=0000", i2.out_aluout); end
    if (i2.out_IR_Exec !== 16'h0) begin n_bad++; $display("FAIL reset_ir got=%h exp=0000", i2.out_IR_Exec); end
    if (i2.out_NZP !== 3'b0) begin n_bad++; $display("FAIL reset_nzp got=%b exp=000", i2.out_NZP); end
    if (count3 !== 2'd0 || i3.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_u3 count=%0d valid=%b exp=0/0", count3, i3.out_valid); end
  endtask
  task automatic test_nzp();
    i2.out_ready = 0;
    set2(2'b00, 16'h8001, 16'h0000, 16'h00f5); i2.in_valid = 1;
    step();
    i2.in_valid = 0;
    n_cmp += 8;
    if (i2.out_valid !== 1'b1) begin n_bad++; $display("FAIL nzp_neg_valid got=%b exp=1", i2.out_valid); end
    if (i2.out_aluout !== 16'h8001) begin n_bad++; $display("FAIL nzp_neg_alu got=%h exp=8001", i2.out_aluout); end
    if (i2.out_NZP !== 3'b100) begin n_bad++; $display("FAIL nzp_neg got=%b exp=100", i2.out_NZP); end
    if (count2 !== 2'd1) begin n_bad++; $display("FAIL nzp_count got=%0d exp=1", count2); end
    if (i2.out_dr !== 3'd5) begin n_bad++; $display("FAIL nzp_dr got=%0d exp=5", i2.out_dr); end
    if (i2.out_sr1 !== 3'd6) begin n_bad++; $display("FAIL nzp_sr1 got=%0d exp=6", i2.out_sr1); end
    if (i2.out_sr2 !== 3'd3) begin n_bad++; $display("FAIL nzp_sr2 got=%0d exp=3", i2.out_sr2); end
    if (i2.out_M_data !== 16'hff0a) begin n_bad++; $display("FAIL nzp_mdata got=%h exp=ff0a", i2.out_M_data); end
    set2(2'b00, 16'h0000, 16'h1234, 16'h0002); i2.in_valid = 1; i2.out_ready = 1;
    step();
    n_cmp += 4;
    if (i2.out_NZP !== 3'b010) begin n_bad++; $display("FAIL nzp_zero got=%b exp=010", i2.out_NZP); end
    if (i2.out_pcout !== 16'h1234) begin n_bad++; $display("FAIL nzp_zero_pc got=%h exp=1234", i2.out_pcout); end
    if (i2.out_IR_Exec !== 16'h0002) begin n_bad++; $display("FAIL nzp_zero_ir got=%h exp=0002", i2.out_IR_Exec); end
    if (count2 !== 2'd1) begin n_bad++; $display("FAIL nzp_pushpop_count got=%0d exp=1", count2); end
    set2(2'b10, 16'hffff, 16'h0005, 16'h0003);
    step();
    n_cmp += 3;
    if (i2.out_NZP !== 3'b001) begin n_bad++; $display("FAIL nzp_pos_pc got=%b exp=001", i2.out_NZP); end
    if (i2.out_W_control !== 2'b10) begin n_bad++; $display("FAIL nzp_wc got=%b exp=10", i2.out_W_control); end
    if (i2.out_pcout !== 16'h0005) begin n_bad++; $display("FAIL nzp_pos_pcout got=%h exp=0005", i2.out_pcout); end
    set2(2'b01, 16'h8000, 16'h0000, 16'h0004);
    step();
    n_cmp += 1;
    if (i2.out_NZP !== 3'b000) begin n_bad++; $display("FAIL nzp_mem got=%b exp=000", i2.out_NZP); end
    set2(2'b10, 16'h0001, 16'h8000, 16'h0005);
    step();
    n_cmp += 1;
    if (i2.out_NZP !== 3'b100) begin n_bad++; $display("FAIL nzp_neg_pc got=%b exp=100", i2.out_NZP); end
    i2.in_valid = 0;
    step();
    n_cmp += 2;
    if (count2 !== 2'd0) begin n_bad++; $display("FAIL nzp_drain_count got=%0d exp=0", count2); end
    if (i2.out_valid !== 1'b0) begin n_bad++; $display("FAIL nzp_drain_valid got=%b exp=0", i2.out_valid); end
  endtask
  task automatic test_back_to_back();
    i2.out_ready = 0;
    set2(2'b00, 16'h0011, 16'h0, 16'h00a1); i2.in_valid = 1;
    step();
    n_cmp += 2;
    if (count2 !== 2'd1) begin n_bad++; $display("FAIL b2b_count_a got=%0d exp=1", count2); end
    if (i2.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_a got=%b exp=1", i2.in_ready); end
    set2(2'b00, 16'h0022, 16'h0, 16'h00b2);
    step();
    n_cmp += 2;
    if (count2 !== 2'd2) begin n_bad++; $display("FAIL b2b_count_b got=%0d exp=2", count2); end
    if (i2.in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_b got=%b exp=0", i2.in_ready); end
    set2(2'b00, 16'h0033, 16'h0, 16'h00c3);
    step();
    n_cmp += 2;
    if (count2 !== 2'd2) begin n_bad++; $display("FAIL b2b_full_count got=%0d exp=2", count2); end
    if (i2.out_IR_Exec !== 16'h00a1) begin n_bad++; $display("FAIL b2b_stable_head got=%h exp=00a1", i2.out_IR_Exec); end
    i2.out_ready = 1;
    step();
    n_cmp += 2;
    if (count2 !== 2'd1) begin n_bad++; $display("FAIL b2b_pop_full_count got=%0d exp=1", count2); end
    if (i2.out_IR_Exec !== 16'h00b2) begin n_bad++; $display("FAIL b2b_pop_a_head got=%h exp=00b2", i2.out_IR_Exec); end
    i2.in_valid = 0;
    step();
    n_cmp += 2;
    if (count2 !== 2'd0) begin n_bad++; $display("FAIL b2b_pop_b_count got=%0d exp=0", count2); end
    if (i2.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty_valid got=%b exp=0", i2.out_valid); end
    i2.out_ready = 0;
  endtask
  task automatic test_stream();
    i3.out_ready = 1;
    i3.in_W_control = 2'b00;
    for (int k = 0; k < 10; k++) begin
      i3.in_IR = 16'h1000 + 16'(k);
      i3.in_aluout = 16'(k);
      i3.in_valid = 1;
      step();
      n_cmp += 3;
      if (i3.out_IR_Exec !== 16'h1000 + 16'(k)) begin n_bad++; $display("FAIL stream_ir[%0d] got=%h exp=%h", k, i3.out_IR_Exec, 16'h1000 + 16'(k)); end
      if (count3 !== 2'd1) begin n_bad++; $display("FAIL stream_count[%0d] got=%0d exp=1", k, count3); end
      if (i3.out_NZP !== (k == 0 ? 3'b010 : 3'b001)) begin n_bad++; $display("FAIL stream_nzp[%0d] got=%b", k, i3.out_NZP); end
    end
    i3.in_valid = 0;
    step();
    n_cmp += 1;
    if (count3 !== 2'd0) begin n_bad++; $display("FAIL stream_drain got=%0d exp=0", count3); end
  endtask
  task automatic test_flush();
    flush2 = 1; step(); flush2 = 0;
    i2.out_ready = 0;
    set2(2'b00, 16'h1, 16'h0, 16'h00a1); i2.in_valid = 1; step();
    set2(2'b00, 16'h2, 16'h0, 16'h00a2); step();
    set2(2'b00, 16'h3, 16'h0, 16'hdead); flush2 = 1; step();
    flush2 = 0; i2.in_valid = 0;
    n_cmp += 4;
    if (count2 !== 2'd0) begin n_bad++; $display("FAIL flush_full_count got=%0d exp=0", count2); end
    if (i2.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_full_valid got=%b exp=0", i2.out_valid); end
    if (i2.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_full_ready got=%b exp=1", i2.in_ready); end
    if (i2.out_IR_Exec !== 16'h00a1) begin n_bad++; $display("FAIL flush_full_data got=%h exp=00a1", i2.out_IR_Exec); end
    set2(2'b00, 16'h4, 16'h0, 16'h00b1); i2.in_valid = 1; step();
    set2(2'b00, 16'h5, 16'h0, 16'h00b2); step();
    i2.in_valid = 0; i2.out_ready = 1; step();
    n_cmp += 1;
    if (i2.out_IR_Exec !== 16'h00b2) begin n_bad++; $display("FAIL flush_setup_head got=%h exp=00b2", i2.out_IR_Exec); end
    set2(2'b00, 16'h6, 16'h0, 16'hbeef); i2.in_valid = 1; flush2 = 1; step();
    flush2 = 0; i2.in_valid = 0; i2.out_ready = 0;
    n_cmp += 3;
    if (count2 !== 2'd0) begin n_bad++; $display("FAIL flush_mid_count got=%0d exp=0", count2); end
    if (i2.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_mid_valid got=%b exp=0", i2.out_valid); end
    if (i2.out_IR_Exec !== 16'h00b1) begin n_bad++; $display("FAIL flush_discard got=%h exp=00b1", i2.out_IR_Exec); end
    set2(2'b00, 16'h7, 16'h0, 16'h7777); i2.in_valid = 1; step();
    i2.in_valid = 0;
    n_cmp += 2;
    if (count2 !== 2'd1) begin n_bad++; $display("FAIL flush_after_count got=%0d exp=1", count2); end
    if (i2.out_IR_Exec !== 16'h7777) begin n_bad++; $display("FAIL flush_after_head got=%h exp=7777", i2.out_IR_Exec); end
    i2.out_ready = 1; step(); i2.out_ready = 0;
  endtask
  task automatic test_reset_full();
    set2(2'b00, 16'h0aaa, 16'h0, 16'h0c01); i2.in_valid = 1; step();
    set2(2'b00, 16'h0bbb, 16'h0, 16'h0c02); step();
    i2.in_valid = 0;
    n_cmp += 1;
    if (count2 !== 2'd2) begin n_bad++; $display("FAIL rstfull_setup got=%0d exp=2", count2); end
    i2.out_ready = 1; reset = 1; step();
    reset = 0; i2.out_ready = 0;
    n_cmp += 5;
    if (count2 !== 2'd0) begin n_bad++; $display("FAIL rstfull_count got=%0d exp=0", count2); end
    if (i2.out_aluout !== 16'h0) begin n_bad++; $display("FAIL rstfull_alu got=%h exp=0000", i2.out_aluout); end
    if (i2.in_ready !== 1'b1) begin n_bad++; $display("FAIL rstfull_ready got=%b exp=1", i2.in_ready); end
    if (i2.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstfull_valid got=%b exp=0", i2.out_valid); end
    if (i2.out_IR_Exec !== 16'h0) begin n_bad++; $display("FAIL rstfull_ir got=%h exp=0000", i2.out_IR_Exec); end
  endtask
  initial begin
    i2.in_valid = 0; i2.out_ready = 0;
    set2(2'b00, 16'h0, 16'h0, 16'h0);
    i3.in_valid = 0; i3.out_ready = 0; i3.in_W_control = 0; i3.in_aluout = 0; i3.in_pcout = 0;
    i3.in_dr = 0; i3.in_sr1 = 0; i3.in_sr2 = 0; i3.in_IR = 0; i3.in_M_data = 0;
    #1;
    test_reset();
    test_nzp();
    test_back_to_back();
    test_stream();
    test_flush();
    test_reset_full();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
